// File: rtl/usb_tx_frame_arbiter.sv
// Round-robin arbiter that copies whole FRAME_WORDS-word frames (2 header words + payload)
// from NUM_SRC sample FIFOs into the FX2 TX FIFO, one frame per USB burst.
module usb_tx_frame_arbiter #(
    parameter int          NUM_SRC     = 2,
    parameter int          FRAME_WORDS = 512,
    parameter logic [15:0] SYNC_WORD   = 16'h7F7F,
    parameter int          SRC_UW      = 11,
    parameter int          TX_FIFO_SZ  = 2048,
    parameter int          TFSZ        = 11
) (
    input  logic                      IFCLK,
    input  logic                      IF_reset_n,
    input  logic                      Enable,
    input  logic [NUM_SRC*SRC_UW-1:0] Src_used,
    input  logic [NUM_SRC*16-1:0]     Src_rdata,
    output logic [NUM_SRC-1:0]        Src_rreq,
    input  logic [TFSZ-1:0]           Tx_fifo_used,
    input  logic                      Tx_fifo_full,
    output logic [15:0]               Tx_fifo_wdata,
    output logic                      Tx_fifo_wreq,
    output logic                      Busy,
    output logic [1:0]                Cur_src,
    output logic [15:0]               Frame_cnt
);

    localparam int                CW       = $clog2(FRAME_WORDS) + 1;
    localparam logic [CW-1:0]     PAY_CNT  = CW'(FRAME_WORDS - 2);
    localparam logic [SRC_UW-1:0] PAY_MIN  = SRC_UW'(FRAME_WORDS - 2);
    localparam logic [TFSZ-1:0]   TX_LIMIT = TFSZ'(TX_FIFO_SZ - FRAME_WORDS);
    localparam logic [1:0]        LAST_SRC = 2'(NUM_SRC - 1);

    typedef enum logic [2:0] {IDLE, ARB, HDR0, HDR1, PAY, FLUSH, DONE} state_t;

    state_t             state_q;
    logic [1:0]         ptr_q;
    logic [11:0]        seq_q;
    logic [CW-1:0]      rcnt_q;
    logic               rdValid_q;
    logic [NUM_SRC-1:0] rreq_q;
    logic [15:0]        wdata_q;
    logic               wreq_q;
    logic               busy_q;
    logic [1:0]         cur_q;
    logic [15:0]        frameCnt_q;

    logic [NUM_SRC-1:0] srcOk;
    logic               txOk;
    logic               grantFound_d;
    logic [1:0]         grantIdx_d;
    logic [NUM_SRC-1:0] curOneHot;
    logic [15:0]        rdSel;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_elig
        assign srcOk[i] = Src_used[i*SRC_UW +: SRC_UW] >= PAY_MIN;
    end

    // Space for a whole frame is reserved at grant, so payload never waits on the TX FIFO.
    assign txOk = !Tx_fifo_full && (Tx_fifo_used <= TX_LIMIT);

    // Smaller rotation offset from ptr wins, so scan offsets from the far end down.
    always_comb begin
        grantFound_d = 1'b0;
        grantIdx_d   = '0;
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (txOk && srcOk[i] && (((int'(ptr_q) + k) % NUM_SRC) == i)) begin
                    grantFound_d = 1'b1;
                    grantIdx_d   = 2'(i);
                end
            end
        end
    end

    always_comb begin
        rdSel     = '0;
        curOneHot = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (cur_q == 2'(i)) begin
                rdSel        = Src_rdata[i*16 +: 16];
                curOneHot[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge IFCLK or negedge IF_reset_n) begin
        if (!IF_reset_n) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            seq_q      <= '0;
            rcnt_q     <= '0;
            rdValid_q  <= 1'b0;
            rreq_q     <= '0;
            wdata_q    <= '0;
            wreq_q     <= 1'b0;
            busy_q     <= 1'b0;
            cur_q      <= '0;
            frameCnt_q <= '0;
        end else begin
            // Read data arrives the cycle after rreq and is written one cycle later.
            rdValid_q <= |rreq_q;
            rreq_q    <= '0;
            wreq_q    <= 1'b0;
            if (rdValid_q) begin
                wreq_q  <= 1'b1;
                wdata_q <= rdSel;
            end

            case (state_q)
                IDLE: begin
                    if (Enable) state_q <= ARB;
                end
                ARB: begin
                    if (!Enable) begin
                        state_q <= IDLE;
                    end else if (grantFound_d) begin
                        cur_q   <= grantIdx_d;
                        busy_q  <= 1'b1;
                        state_q <= HDR0;
                    end
                end
                HDR0: begin
                    wreq_q  <= 1'b1;
                    wdata_q <= SYNC_WORD;
                    state_q <= HDR1;
                end
                HDR1: begin
                    wreq_q  <= 1'b1;
                    wdata_q <= {2'b00, cur_q, seq_q};
                    rreq_q  <= curOneHot;
                    rcnt_q  <= CW'(1);
                    state_q <= PAY;
                end
                PAY: begin
                    if (rcnt_q == PAY_CNT) begin
                        state_q <= FLUSH;
                    end else begin
                        rreq_q <= curOneHot;
                        rcnt_q <= rcnt_q + CW'(1);
                    end
                end
                FLUSH: begin
                    if (!rdValid_q) begin
                        busy_q     <= 1'b0;
                        frameCnt_q <= frameCnt_q + 16'd1;
                        seq_q      <= seq_q + 12'd1;
                        ptr_q      <= (cur_q == LAST_SRC) ? 2'd0 : cur_q + 2'd1;
                        state_q    <= DONE;
                    end
                end
                DONE: begin
                    state_q <= ARB;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign Src_rreq      = rreq_q;
    assign Tx_fifo_wdata = wdata_q;
    assign Tx_fifo_wreq  = wreq_q;
    assign Busy          = busy_q;
    assign Cur_src       = cur_q;
    assign Frame_cnt     = frameCnt_q;

    noWriteWhenFull: assert property (@(posedge IFCLK) disable iff (!IF_reset_n)
                                      !(Tx_fifo_wreq && Tx_fifo_full));

endmodule

// File: tb/tb_usb_tx_frame_arbiter.sv
// Directed bench for usb_tx_frame_arbiter: full-size instance for frame content/arbitration,
// a short-frame instance for the 12-bit sequence wrap.
module tb_usb_tx_frame_arbiter;

    logic        IFCLK = 1'b0;
    logic        rst_n;
    logic        Enable;
    logic [21:0] Src_used;
    logic [31:0] Src_rdata;
    logic [1:0]  Src_rreq;
    logic [10:0] Tx_fifo_used;
    logic        Tx_fifo_full;
    logic [15:0] Tx_fifo_wdata;
    logic        Tx_fifo_wreq;
    logic        Busy;
    logic [1:0]  Cur_src;
    logic [15:0] Frame_cnt;

    logic        rstB_n;
    logic        enableB;
    logic [21:0] srcUsedB;
    logic [1:0]  srcRreqB;
    logic [15:0] wdataB;
    logic        wreqB;
    logic        busyB;
    logic [1:0]  curSrcB;
    logic [15:0] frameCntB;

    int checks   = 0;
    int failures = 0;

    always #10 IFCLK = ~IFCLK;

    usb_tx_frame_arbiter dut (
        .IFCLK(IFCLK), .IF_reset_n(rst_n), .Enable(Enable),
        .Src_used(Src_used), .Src_rdata(Src_rdata), .Src_rreq(Src_rreq),
        .Tx_fifo_used(Tx_fifo_used), .Tx_fifo_full(Tx_fifo_full),
        .Tx_fifo_wdata(Tx_fifo_wdata), .Tx_fifo_wreq(Tx_fifo_wreq),
        .Busy(Busy), .Cur_src(Cur_src), .Frame_cnt(Frame_cnt)
    );

    usb_tx_frame_arbiter #(.FRAME_WORDS(4)) dutB (
        .IFCLK(IFCLK), .IF_reset_n(rstB_n), .Enable(enableB),
        .Src_used(srcUsedB), .Src_rdata(32'h5555_5555), .Src_rreq(srcRreqB),
        .Tx_fifo_used(11'd0), .Tx_fifo_full(1'b0),
        .Tx_fifo_wdata(wdataB), .Tx_fifo_wreq(wreqB),
        .Busy(busyB), .Cur_src(curSrcB), .Frame_cnt(frameCntB)
    );

    function automatic logic [15:0] wordOf(input int s, input int k);
        return (s == 0 ? 16'hA000 : 16'hB000) + 16'(k % 4096);
    endfunction

    // Source FIFO model: data for a read request shows up on the following cycle.
    logic [15:0] srcData [2];
    int          srcCnt  [2];
    always @(posedge IFCLK) begin
        for (int i = 0; i < 2; i++) begin
            if (Src_rreq[i]) begin
                srcData[i] <= wordOf(i, srcCnt[i]);
                srcCnt[i]  <= srcCnt[i] + 1;
            end
        end
    end
    assign Src_rdata = {srcData[1], srcData[0]};

    logic [15:0] wq[$];
    int          wc[$];
    int          cyc;
    int          rreqCnt;
    always @(posedge IFCLK) cyc <= cyc + 1;
    always @(negedge IFCLK) begin
        if (Tx_fifo_wreq) begin
            wq.push_back(Tx_fifo_wdata);
            wc.push_back(cyc);
        end
        if (|Src_rreq) rreqCnt++;
    end

    int          wrCntB;
    logic [15:0] prevHdrB;
    logic [15:0] lastHdrB;
    always @(negedge IFCLK) begin
        if (wreqB) begin
            if (wrCntB % 4 == 1) begin
                prevHdrB = lastHdrB;
                lastHdrB = wdataB;
            end
            wrCntB++;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, want %0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic en, input int u0, input int u1, input int tx);
        @(negedge IFCLK);
        Enable       = en;
        Src_used     = {11'(u1), 11'(u0)};
        Tx_fifo_used = 11'(tx);
    endtask

    task automatic doReset();
        @(negedge IFCLK);
        rst_n = 1'b0;
        repeat (2) @(negedge IFCLK);
        rst_n = 1'b1;
    endtask

    task automatic waitFrame(input logic [15:0] target, input int budget);
        int n = 0;
        while (Frame_cnt != target && n < budget) begin
            @(negedge IFCLK);
            n++;
        end
    endtask

    task automatic waitWrites(input int target, input int budget);
        int n = 0;
        while (wq.size() < target && n < budget) begin
            @(negedge IFCLK);
            n++;
        end
    endtask

    task automatic checkFrame(input string tag, input int off, input logic [15:0] hdr2,
                              input int src, input int base);
        int errs = 0;
        logic [15:0] w0 = 16'h0;
        logic [15:0] w1 = 16'h0;
        if (wq.size() < off + 512) begin
            errs = 510;
        end else begin
            w0 = wq[off];
            w1 = wq[off + 1];
            for (int k = 0; k < 510; k++)
                if (wq[off + 2 + k] !== wordOf(src, base + k)) errs++;
        end
        checkOutput({tag, " sync"}, 32'(w0), 32'(16'h7F7F));
        checkOutput({tag, " hdr2"}, 32'(w1), 32'(hdr2));
        checkOutput({tag, " payload_errs"}, 32'(errs), 32'd0);
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, " rreq"},  32'(Src_rreq), 32'd0);
        checkOutput({tag, " wreq"},  32'(Tx_fifo_wreq), 32'd0);
        checkOutput({tag, " wdata"}, 32'(Tx_fifo_wdata), 32'd0);
        checkOutput({tag, " busy"},  32'(Busy), 32'd0);
        checkOutput({tag, " cur"},   32'(Cur_src), 32'd0);
        checkOutput({tag, " frames"}, 32'(Frame_cnt), 32'd0);
    endtask

    initial begin
        int base0;
        int base1;
        rst_n        = 1'b0;
        rstB_n       = 1'b0;
        Enable       = 1'b0;
        enableB      = 1'b0;
        Src_used     = '0;
        srcUsedB     = '0;
        Tx_fifo_used = '0;
        Tx_fifo_full = 1'b0;

        // 1: single frame from src0
        @(negedge IFCLK);
        checkResetOutputs("t1 reset");
        rst_n = 1'b1;
        base0 = srcCnt[0];
        applyStimulus(1'b1, 600, 0, 0);
        waitFrame(16'd1, 700);
        checkOutput("t1 frame_cnt", 32'(Frame_cnt), 32'd1);
        checkOutput("t1 busy_done", 32'(Busy), 32'd0);
        checkOutput("t1 wreq_count", 32'(wq.size()), 32'd512);
        checkFrame("t1", 0, 16'h0000, 0, base0);
        if (wc.size() >= 512) begin
            checkOutput("t1 hdr_gap", 32'(wc[1] - wc[0]), 32'd1);
            checkOutput("t1 pay_gap", 32'(wc[2] - wc[1]), 32'd2);
            checkOutput("t1 pay_contig", 32'(wc[511] - wc[2]), 32'd509);
        end else begin
            checkOutput("t1 timing_words", 32'(wc.size()), 32'd512);
        end
        Enable = 1'b0;

        // 2: round robin across two full sources
        doReset();
        wq.delete(); wc.delete();
        base0 = srcCnt[0];
        base1 = srcCnt[1];
        applyStimulus(1'b1, 1000, 1000, 0);
        waitFrame(16'd4, 2400);
        Enable = 1'b0;
        checkOutput("t2 frame_cnt", 32'(Frame_cnt), 32'd4);
        checkOutput("t2 wreq_count", 32'(wq.size()), 32'd2048);
        checkFrame("t2 f0", 0,    16'h0000, 0, base0);
        checkFrame("t2 f1", 512,  16'h1001, 1, base1);
        checkFrame("t2 f2", 1024, 16'h0002, 0, base0 + 510);
        checkFrame("t2 f3", 1536, 16'h1003, 1, base1 + 510);

        // 3: TX FIFO space boundary
        doReset();
        wq.delete(); wc.delete();
        rreqCnt = 0;
        applyStimulus(1'b1, 600, 0, 1537);
        repeat (12) @(negedge IFCLK);
        checkOutput("t3 no_grant_busy", 32'(Busy), 32'd0);
        checkOutput("t3 no_grant_rreq", 32'(rreqCnt), 32'd0);
        checkOutput("t3 no_grant_wreq", 32'(wq.size()), 32'd0);
        applyStimulus(1'b1, 600, 0, 1536);
        repeat (2) @(negedge IFCLK);
        checkOutput("t3 grant_busy", 32'(Busy), 32'd1);
        checkOutput("t3 grant_src", 32'(Cur_src), 32'd0);
        waitFrame(16'd1, 700);
        Enable = 1'b0;
        checkOutput("t3 frame_cnt", 32'(Frame_cnt), 32'd1);

        // 4: Enable dropped mid-payload
        repeat (4) @(negedge IFCLK);
        wq.delete(); wc.delete();
        rreqCnt = 0;
        base0 = srcCnt[0];
        applyStimulus(1'b1, 600, 0, 1536);
        waitWrites(102, 300);
        Enable = 1'b0;
        waitFrame(16'd2, 700);
        checkOutput("t4 frame_cnt", 32'(Frame_cnt), 32'd2);
        checkOutput("t4 wreq_count", 32'(wq.size()), 32'd512);
        checkFrame("t4", 0, 16'h0001, 0, base0);
        repeat (20) @(negedge IFCLK);
        checkOutput("t4 idle_busy", 32'(Busy), 32'd0);
        checkOutput("t4 idle_wreq", 32'(wq.size()), 32'd512);
        checkOutput("t4 idle_rreq", 32'(rreqCnt), 32'd510);

        // 5: async reset in the middle of a src1 payload
        wq.delete(); wc.delete();
        applyStimulus(1'b1, 600, 600, 1536);
        waitWrites(52, 300);
        checkOutput("t5 pre_reset_src", 32'(Cur_src), 32'd1);
        #3 rst_n = 1'b0;
        #1 checkResetOutputs("t5 async");
        repeat (2) @(negedge IFCLK);
        wq.delete(); wc.delete();
        base0 = srcCnt[0];
        rst_n = 1'b1;
        waitFrame(16'd1, 700);
        Enable = 1'b0;
        checkOutput("t5 frame_cnt", 32'(Frame_cnt), 32'd1);
        checkOutput("t5 wreq_count", 32'(wq.size()), 32'd512);
        checkFrame("t5", 0, 16'h0000, 0, base0);

        // 6: sequence wrap on the short-frame instance
        @(negedge IFCLK);
        rstB_n   = 1'b1;
        srcUsedB = {11'd600, 11'd600};
        enableB  = 1'b1;
        for (int n = 0; n < 40000 && frameCntB != 16'd4097; n++) @(negedge IFCLK);
        enableB = 1'b0;
        checkOutput("t6 frame_cnt", 32'(frameCntB), 32'd4097);
        checkOutput("t6 hdr2_4096", 32'(prevHdrB), 32'h1FFF);
        checkOutput("t6 hdr2_4097", 32'(lastHdrB), 32'h0000);
        checkOutput("t6 wreq_total", 32'(wrCntB), 32'(4097 * 4));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
